// File: rtl/camera_sccb_if.sv
// Avalon-MM register bus between the Nios master and the SCCB transmitter.
// Latency: reads return one clk after the read strobe; writes take effect on the strobe edge.
// Backpressure: none; the slave never stalls, so there is no waitrequest.
interface camera_sccb_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (output address, output write, output writedata, output read, input readdata);
    modport slave  (input address, input write, input writedata, input read, output readdata);
endinterface

// File: rtl/camera_sccb_tx.sv
// Serializes camera register writes (device ID, register address, data) onto the SCCB bus.
// Latency: a transaction lasts 113*(CLKDIV+1) clk cycles; register reads take one cycle.
// Backpressure: none; writes while busy are dropped and flagged in STATUS.overrun.
// Optional feature: define SCCB_ACK_CHECK_EN to sample the don't-care bits and flag STATUS.nack.
module camera_sccb_tx #(
    parameter logic [15:0] DEF_CLKDIV = 16'd124,
    parameter logic [7:0]  DEF_DEVID  = 8'h42
) (
    input  logic          clk,
    input  logic          reset_n,
    camera_sccb_if.slave  bus,
    output logic          sioc,
    output logic          siod_out,
    output logic          siod_oe,
    input  logic          siod_in
);
    typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ph_q, ph_d;          // phase within START/STOP, quarter within a bit
    logic [4:0]  bit_q, bit_d;        // bit index 0..26
    logic [26:0] sh_q, sh_d;          // outgoing bits, MSB is on the wire
    logic [15:0] div_q, div_d;
    logic [15:0] clkdiv_l_q, clkdiv_l_d;
    logic [15:0] clkdiv_q, clkdiv_d;
    logic [7:0]  devid_q, devid_d;
    logic        done_q, done_d, ovr_q, ovr_d, nack_q, nack_d;
    logic [31:0] readdata_q, readdata_d;

    logic busy, tick, dc_bit, accept, set_done, set_ovr, set_nack;
    logic [2:0] clr;

    assign busy   = (state_q != IDLE);
    assign tick   = busy && (div_q == clkdiv_l_q);
    // The ninth bit of each byte is the released don't-care (ACK) slot.
    assign dc_bit = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);
    assign bus.readdata = readdata_q;

    logic unused_bits;
    assign unused_bits = ^bus.writedata[31:16];

    // Register file, divider and transaction sequencer next-state.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        div_d      = div_q;
        clkdiv_l_d = clkdiv_l_q;
        clkdiv_d   = clkdiv_q;
        devid_d    = devid_q;
        readdata_d = readdata_q;
        accept     = 1'b0;
        set_done   = 1'b0;
        set_ovr    = 1'b0;
        set_nack   = 1'b0;
        clr        = 3'b000;

        if (bus.write) begin
            case (bus.address)
                2'd0: if (busy) set_ovr = 1'b1; else accept = 1'b1;
                2'd1: clr = bus.writedata[3:1];
                2'd2: if (busy) set_ovr = 1'b1; else clkdiv_d = bus.writedata[15:0];
                default: if (busy) set_ovr = 1'b1; else devid_d = bus.writedata[7:0];
            endcase
        end

        if (busy) div_d = tick ? 16'd0 : div_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    ph_d       = 2'd0;
                    bit_d      = 5'd0;
                    div_d      = 16'd0;
                    clkdiv_l_d = clkdiv_q;
                    sh_d       = {devid_q, 1'b1, bus.writedata[15:8], 1'b1, bus.writedata[7:0], 1'b1};
                end
            end
            START: begin
                if (tick) begin
                    if (ph_q == 2'd1) begin
                        state_d = BIT;
                        ph_d    = 2'd0;
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end
            end
            BIT: begin
                if (tick) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        if (bit_q == 5'd26) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 5'd1;
                            sh_d  = {sh_q[25:0], 1'b1};
                        end
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (ph_q == 2'd2) begin
                        state_d  = IDLE;
                        set_done = 1'b1;
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end
            end
        endcase

`ifdef SCCB_ACK_CHECK_EN
        set_nack = (state_q == BIT) && tick && (ph_q == 2'd2) && dc_bit && siod_in;
`else
        set_nack = 1'b0;
`endif

        // Sticky flags: a set on the same edge as a clear wins.
        done_d = set_done | (done_q & ~clr[0]);
        ovr_d  = set_ovr  | (ovr_q  & ~clr[1]);
        nack_d = set_nack | (nack_q & ~clr[2]);

        if (bus.read) begin
            case (bus.address)
                2'd0:    readdata_d = 32'd0;
                2'd1:    readdata_d = {28'd0, nack_q, ovr_q, done_q, busy};
                2'd2:    readdata_d = {16'd0, clkdiv_q};
                default: readdata_d = {24'd0, devid_q};
            endcase
        end
    end

`ifndef SCCB_ACK_CHECK_EN
    logic unused_siod;
    assign unused_siod = siod_in;
`endif

    // SCCB pin levels decoded from the sequencer position.
    always_comb begin
        sioc     = 1'b1;
        siod_out = 1'b1;
        siod_oe  = 1'b1;
        case (state_q)
            START: begin
                sioc     = (ph_q == 2'd0);
                siod_out = 1'b0;
            end
            BIT: begin
                sioc     = ph_q[1];
                siod_out = dc_bit ? 1'b1 : sh_q[26];
                siod_oe  = ~dc_bit;
            end
            STOP: begin
                sioc     = (ph_q != 2'd0);
                siod_out = (ph_q == 2'd2);
            end
            default: ;
        endcase
    end

    // State registers; reset aborts any transaction without a STOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ph_q       <= 2'd0;
            bit_q      <= 5'd0;
            sh_q       <= '1;
            div_q      <= 16'd0;
            clkdiv_l_q <= DEF_CLKDIV;
            clkdiv_q   <= DEF_CLKDIV;
            devid_q    <= DEF_DEVID;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            nack_q     <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            div_q      <= div_d;
            clkdiv_l_q <= clkdiv_l_d;
            clkdiv_q   <= clkdiv_d;
            devid_q    <= devid_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            nack_q     <= nack_d;
            readdata_q <= readdata_d;
        end
    end
endmodule

// File: tb/tb_camera_sccb_tx.sv
// Self-checking bench for camera_sccb_tx: directed sequence plus randomized transfers.
// Expected bus waveforms are built from the byte values and the SCCB phase rules.
// Also decodes the bus at sioc rising edges and compares the recovered bytes.
module tb_camera_sccb_tx;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic siod_in = 1'b1;
    logic sioc, siod_out, siod_oe;

    camera_sccb_if bus_if();

    camera_sccb_tx dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .sioc     (sioc),
        .siod_out (siod_out),
        .siod_oe  (siod_oe),
        .siod_in  (siod_in)
    );

    always #5 clk = ~clk;

`ifdef SCCB_ACK_CHECK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the register state.
    logic        m_done, m_ovr, m_nack;
    logic [15:0] m_clkdiv;
    logic [7:0]  m_devid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {28'd0, m_nack, m_ovr, m_done, 1'b0};
    endfunction

    task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.address   = a;
        bus_if.writedata = d;
        bus_if.write     = 1'b1;
        @(posedge clk); #1;
        bus_if.write     = 1'b0;
    endtask

    task automatic avm_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.address = a;
        bus_if.read    = 1'b1;
        @(posedge clk); #1;
        bus_if.read    = 1'b0;
        d = bus_if.readdata;
    endtask

    // inj: 0 none, 1 CMD+CLKDIV writes mid-transfer, 2 CMD write on the last busy cycle.
    task automatic run_xfer(input logic [15:0] cmd, input int inj);
        int c, n, k, rises_dc;
        logic [2:0] ph[113];
        logic [2:0] mk[113];
        logic [7:0] by[3];
        logic [7:0] got;
        logic [2:0] e, m;
        logic v, dc, prev_sioc;
        logic bits[$];

        c = int'(m_clkdiv);
        n = 113 * (c + 1);
        by[0] = m_devid; by[1] = cmd[15:8]; by[2] = cmd[7:0];
        ph[0] = 3'b101; mk[0] = 3'b111;
        ph[1] = 3'b001; mk[1] = 3'b111;
        for (int b = 0; b < 27; b++) begin
            dc = ((b % 9) == 8);
            v  = dc ? 1'b1 : by[b / 9][7 - (b % 9)];
            for (int q = 0; q < 4; q++) begin
                ph[2 + 4 * b + q] = {(q >= 2), v, ~dc};
                mk[2 + 4 * b + q] = dc ? 3'b101 : 3'b111;
            end
        end
        ph[110] = 3'b001; ph[111] = 3'b101; ph[112] = 3'b111;
        mk[110] = 3'b111; mk[111] = 3'b111; mk[112] = 3'b111;

        avm_write(2'd0, {16'd0, cmd});
        rises_dc  = 0;
        prev_sioc = 1'b1;
        for (int i = 0; i <= n + 1; i++) begin
            if (i < n) begin
                k = i / (c + 1);
                e = ph[k];
                m = mk[k];
            end else begin
                e = 3'b111;
                m = 3'b111;
            end
            chk("bus_pins", {29'd0, {sioc, siod_out, siod_oe} & m}, {29'd0, e & m});
            if (!prev_sioc && sioc) begin
                if (siod_oe) bits.push_back(siod_out);
                else rises_dc++;
            end
            prev_sioc = sioc;
            if (i >= 1 && i <= n) chk("busy_during", {31'd0, bus_if.readdata[0]}, 32'd1);
            if (i == n + 1) begin
                m_done = 1'b1;
                if (ACK_EN) m_nack = 1'b1;
                chk("status_end", bus_if.readdata, status_exp());
            end
            bus_if.write   = 1'b0;
            bus_if.read    = 1'b1;
            bus_if.address = 2'd1;
            if ((inj == 1 && i == 20) || (inj == 2 && i == n - 1)) begin
                bus_if.address   = 2'd0;
                bus_if.writedata = $urandom;
                bus_if.write     = 1'b1;
                bus_if.read      = 1'b0;
                m_ovr            = 1'b1;
            end
            if (inj == 1 && i == 30) begin
                bus_if.address   = 2'd2;
                bus_if.writedata = 32'd5;
                bus_if.write     = 1'b1;
                bus_if.read      = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus_if.read  = 1'b0;
        bus_if.write = 1'b0;

        chk("decoded_nbits", bits.size(), 32'd25);
        chk("dc_rises", rises_dc, 32'd3);
        for (int y = 0; y < 3; y++) begin
            got = 8'd0;
            for (int j = 0; j < 8; j++)
                if (bits.size() > 8 * y + j) got = {got[6:0], bits[8 * y + j]};
            chk("decoded_byte", {24'd0, got}, {24'd0, by[y]});
        end
        if (bits.size() > 24) chk("stop_bit_low", {31'd0, bits[24]}, 32'd0);
    endtask

    logic [31:0] d;
    logic [15:0] rc;
    logic [7:0]  rd;

    initial begin
        bus_if.address   = 2'd0;
        bus_if.write     = 1'b0;
        bus_if.writedata = 32'd0;
        bus_if.read      = 1'b0;
        m_done = 1'b0; m_ovr = 1'b0; m_nack = 1'b0;
        m_clkdiv = 16'd124; m_devid = 8'h42;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pins", {29'd0, sioc, siod_out, siod_oe}, 32'd7);
        chk("rst_readdata", bus_if.readdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        avm_read(2'd2, d); chk("rst_clkdiv", d, 32'd124);
        avm_read(2'd3, d); chk("rst_devid", d, 32'h42);
        avm_read(2'd1, d); chk("rst_status", d, 32'd0);
        avm_read(2'd0, d); chk("cmd_reads_0", d, 32'd0);

        // Basic transfer with overrun attempts while busy.
        avm_write(2'd2, 32'd0); m_clkdiv = 16'd0;
        avm_write(2'd3, 32'h42); m_devid = 8'h42;
        run_xfer(16'h1280, 1);
        avm_read(2'd2, d); chk("clkdiv_unchanged", d, 32'd0);
        avm_write(2'd1, 32'h6); m_done = 1'b0; m_ovr = 1'b0;
        avm_read(2'd1, d); chk("status_clr_6", d, status_exp());
        avm_write(2'd1, 32'h8); m_nack = 1'b0;
        avm_read(2'd1, d); chk("status_clr_8", d, 32'd0);

        // CMD on the cycle busy falls is dropped; the next one is accepted.
        run_xfer(16'h3344, 2);
        run_xfer(16'h5566, 0);
        avm_write(2'd1, 32'hE); m_done = 1'b0; m_ovr = 1'b0; m_nack = 1'b0;

        // Slower divider: each phase is 4 cycles, 452 busy cycles.
        avm_write(2'd2, 32'd3); m_clkdiv = 16'd3;
        run_xfer(16'h0A55, 0);
        avm_write(2'd1, 32'hE); m_done = 1'b0; m_ovr = 1'b0; m_nack = 1'b0;

        // Randomized transfers.
        for (int r = 0; r < 3; r++) begin
            rc = 16'($urandom_range(0, 3));
            rd = 8'($urandom);
            avm_write(2'd2, {16'd0, rc}); m_clkdiv = rc;
            avm_write(2'd3, {24'd0, rd}); m_devid = rd;
            avm_read(2'd3, d); chk("devid_rw", d, {24'd0, rd});
            run_xfer(16'($urandom), 0);
            avm_write(2'd1, 32'hE); m_done = 1'b0; m_ovr = 1'b0; m_nack = 1'b0;
        end

        // Reset in the middle of a transfer.
        avm_write(2'd2, 32'd0); m_clkdiv = 16'd0;
        avm_write(2'd0, 32'h1234);
        repeat (40) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_pins", {29'd0, sioc, siod_out, siod_oe}, 32'd7);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_done = 1'b0; m_ovr = 1'b0; m_nack = 1'b0;
        m_clkdiv = 16'd124; m_devid = 8'h42;
        avm_read(2'd1, d); chk("midrst_status", d, 32'd0);
        avm_read(2'd2, d); chk("midrst_clkdiv", d, 32'd124);
        avm_write(2'd2, 32'd1); m_clkdiv = 16'd1;
        run_xfer(16'hC3A5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
